// File: rtl/mem_resp_sram.sv
// Single-port word SRAM behind a req/gnt data port. Responses come back in
// grant order through a fixed-latency {valid, rdata, err} shift chain.
module mem_resp_sram #(
    parameter int ADDRESS_SIZE = 64,
    parameter int DEPTH        = 1024,
    parameter int LATENCY      = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDRESS_SIZE-1:0] address_i,
    input  logic [31:0]             data_wdata_i,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [3:0]              data_be_i,
    input  logic                    stall_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [31:0]             data_rdata_o,
    output logic                    err_o
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] OOR_RDATA = 32'hDEADBEEF;

    logic [31:0]              mem_q [DEPTH];
    logic [LATENCY-1:0]       vld_q, vld_d;
    logic [LATENCY-1:0][31:0] rdata_q, rdata_d;
    logic [LATENCY-1:0]       err_q, err_d;

    logic                    gnt;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;
    logic [ADDRESS_SIZE-3:0] word_addr;

    assign gnt        = data_req_i & ~stall_i & ~rst_i;
    assign data_gnt_o = gnt;
    assign word_addr  = address_i[ADDRESS_SIZE-1:2];
    assign idx        = address_i[2 +: IDX_W];
    // Any word-address bit above the index field set means past the array.
    assign in_range   = (word_addr >> IDX_W) == '0;

    // Contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (gnt && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        vld_d   = '0;
        rdata_d = '0;
        err_d   = '0;
        vld_d[0] = gnt;
        if (gnt) begin
            if (!in_range) begin
                err_d[0]   = 1'b1;
                rdata_d[0] = data_we_i ? 32'h0 : OOR_RDATA;
            end else if (!data_we_i) begin
                rdata_d[0] = mem_q[idx];
            end
        end
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            rdata_d[i] = rdata_q[i-1];
            err_d[i]   = err_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign data_rvalid_o = vld_q[LATENCY-1];
    assign data_rdata_o  = rdata_q[LATENCY-1];
    assign err_o         = err_q[LATENCY-1];

endmodule

// File: tb/tb_mem_resp_sram.sv
// Drives one request stream into three instances (LATENCY 1, 2, 3) and checks
// each response pipe against hand-computed expectations.
module tb_mem_resp_sram;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic        req, we, stall;
    logic [3:0]  be;
    logic [2:0]       gnt, rv, er;
    logic [2:0][31:0] rd;

    int checks = 0;
    int failures = 0;
    int lat [3] = '{1, 2, 3};
    vec_t tbl [18];
    vec_t bq [$];

    always #5 clk = ~clk;

    mem_resp_sram #(.LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .address_i(addr), .data_wdata_i(wdata),
        .data_req_i(req), .data_we_i(we), .data_be_i(be), .stall_i(stall),
        .data_gnt_o(gnt[0]), .data_rvalid_o(rv[0]), .data_rdata_o(rd[0]), .err_o(er[0]));
    mem_resp_sram #(.LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_i(rst), .address_i(addr), .data_wdata_i(wdata),
        .data_req_i(req), .data_we_i(we), .data_be_i(be), .stall_i(stall),
        .data_gnt_o(gnt[1]), .data_rvalid_o(rv[1]), .data_rdata_o(rd[1]), .err_o(er[1]));
    mem_resp_sram #(.LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_i(rst), .address_i(addr), .data_wdata_i(wdata),
        .data_req_i(req), .data_we_i(we), .data_be_i(be), .stall_i(stall),
        .data_gnt_o(gnt[2]), .data_rvalid_o(rv[2]), .data_rdata_o(rd[2]), .err_o(er[2]));

    function automatic vec_t mk(logic w, logic [63:0] a, logic [3:0] b, logic [31:0] d,
                                logic [31:0] er_d, logic ee);
        vec_t v;
        v.we = w; v.addr = a; v.be = b; v.wdata = d; v.exp_rdata = er_d; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut_lat%0d t=%0t got=%h want=%h", name, lat[d], $time, act, exp);
        end
    endtask

    task automatic chk_idle(string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_rvalid"}, d, {31'h0, rv[d]}, 32'h0);
            chk({tag, "_rdata"},  d, rd[d], 32'h0);
            chk({tag, "_err"},    d, {31'h0, er[d]}, 32'h0);
        end
    endtask

    // Grants every entry of bq on consecutive cycles; checks gnt and all three
    // response pipes cycle by cycle. Entered and left 1ns after a rising edge.
    task automatic run_burst();
        int n = bq.size();
        for (int t = 0; t < n + 4; t++) begin
            if (t < n) begin
                req = 1'b1; we = bq[t].we; addr = bq[t].addr;
                be = bq[t].be; wdata = bq[t].wdata;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                int j = t - lat[d];
                chk("gnt", d, {31'h0, gnt[d]}, {31'h0, (t < n)});
                if (j >= 0 && j < n) begin
                    chk("rvalid", d, {31'h0, rv[d]}, 32'h1);
                    chk("rdata",  d, rd[d], bq[j].exp_rdata);
                    chk("err",    d, {31'h0, er[d]}, {31'h0, bq[j].exp_err});
                end else begin
                    chk("rvalid_idle", d, {31'h0, rv[d]}, 32'h0);
                    chk("rdata_idle",  d, rd[d], 32'h0);
                    chk("err_idle",    d, {31'h0, er[d]}, 32'h0);
                end
            end
            @(posedge clk); #1;
        end
        bq.delete();
    endtask

    initial begin
        tbl[0]  = mk(1, 64'h10,   4'hF, 32'hA5A51234, 32'h0,        0);
        tbl[1]  = mk(0, 64'h10,   4'h0, 32'h0,        32'hA5A51234, 0);
        tbl[2]  = mk(1, 64'h10,   4'h2, 32'h0000FF00, 32'h0,        0);
        tbl[3]  = mk(0, 64'h10,   4'h0, 32'h0,        32'hA5A5FF34, 0);
        tbl[4]  = mk(1, 64'h0,    4'hF, 32'h11223344, 32'h0,        0);
        tbl[5]  = mk(1, 64'h4,    4'hF, 32'h55667788, 32'h0,        0);
        tbl[6]  = mk(1, 64'h8,    4'hF, 32'h99AABBCC, 32'h0,        0);
        tbl[7]  = mk(0, 64'h1000, 4'h0, 32'h0,        32'hDEADBEEF, 1);
        tbl[8]  = mk(1, 64'h1000, 4'hF, 32'hFFFFFFFF, 32'h0,        1);
        tbl[9]  = mk(0, 64'h0,    4'h0, 32'h0,        32'h11223344, 0);
        tbl[10] = mk(1, 64'h4,    4'h0, 32'hFFFFFFFF, 32'h0,        0);
        tbl[11] = mk(0, 64'h6,    4'h0, 32'h0,        32'h55667788, 0);
        tbl[12] = mk(1, 64'h8,    4'h9, 32'h01FFFF02, 32'h0,        0);
        tbl[13] = mk(0, 64'h8,    4'h0, 32'h0,        32'h01AABB02, 0);
        tbl[14] = mk(0, 64'h1_0000_0000_0010, 4'h0, 32'h0, 32'hDEADBEEF, 1);
        tbl[15] = mk(1, 64'hFFC,  4'hF, 32'hCAFEF00D, 32'h0,        0);
        tbl[16] = mk(0, 64'hFFC,  4'h0, 32'h0,        32'hCAFEF00D, 0);
        tbl[17] = mk(0, 64'h0,    4'h0, 32'h0,        32'h11223344, 0);

        // Reset with a request pending: no grant, outputs quiet.
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = '0; be = '0; wdata = '0; stall = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("gnt_in_reset", d, {31'h0, gnt[d]}, 32'h0);
        chk_idle("reset");
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;

        foreach (tbl[i]) begin
            bq.push_back(tbl[i]);
            run_burst();
        end

        // Back-to-back reads, then read/write/read on one word: the first
        // read must return the value captured before the write.
        bq.push_back(mk(0, 64'h0, 4'h0, 32'h0, 32'h11223344, 0));
        bq.push_back(mk(0, 64'h4, 4'h0, 32'h0, 32'h55667788, 0));
        bq.push_back(mk(0, 64'h8, 4'h0, 32'h0, 32'h01AABB02, 0));
        run_burst();
        bq.push_back(mk(0, 64'h0, 4'h0, 32'h0,        32'h11223344, 0));
        bq.push_back(mk(1, 64'h0, 4'hF, 32'hDEADC0DE, 32'h0,        0));
        bq.push_back(mk(0, 64'h0, 4'h0, 32'h0,        32'hDEADC0DE, 0));
        bq.push_back(mk(1, 64'h2000, 4'hF, 32'h0,     32'h0,        1));
        run_burst();

        // Stall five cycles with the request held, then accept.
        stall = 1'b1; req = 1'b1; we = 1'b0; addr = 64'h10; be = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) chk("gnt_stalled", d, {31'h0, gnt[d]}, 32'h0);
            chk_idle("stalled");
            @(posedge clk); #1;
        end
        stall = 1'b0;
        bq.push_back(mk(0, 64'h10, 4'h0, 32'h0, 32'hA5A5FF34, 0));
        run_burst();

        // Grant a read, then pulse reset: the response must never appear.
        req = 1'b1; we = 1'b0; addr = 64'h4;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("gnt_pre_rst", d, {31'h0, gnt[d]}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("gnt_mid_rst", d, {31'h0, gnt[d]}, 32'h0);
        chk_idle("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_idle("post_rst");
            @(posedge clk); #1;
        end

        // Memory survives reset.
        bq.push_back(mk(0, 64'h4, 4'h0, 32'h0, 32'h55667788, 0));
        run_burst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_resp_sram.md
MEM_RESP_SRAM -- requirements
Module: mem_resp_sram

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 64: request address width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024: number of 32-bit words; power of two, at least 2.
REQ-003 SHALL have parameter LATENCY, default 1: cycles from grant to rvalid; legal range 1..4.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port address_i, input, ADDRESS_SIZE bits: byte address of the request.
REQ-007 SHALL have port data_wdata_i, input, 32 bits: write data.
REQ-008 SHALL have port data_req_i, input, 1 bit: request valid.
REQ-009 SHALL have port data_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port data_be_i, input, 4 bits: byte enables for writes.
REQ-011 SHALL have port stall_i, input, 1 bit: test hook that suppresses grant.
REQ-012 SHALL have port data_gnt_o, output, 1 bit: request accepted this cycle.
REQ-013 SHALL have port data_rvalid_o, output, 1 bit: response valid.
REQ-014 SHALL have port data_rdata_o, output, 32 bits: read data.
REQ-015 SHALL have port err_o, output, 1 bit: out-of-range error, qualified by data_rvalid_o.

Function
REQ-016 Grant rule: data_gnt_o = data_req_i & ~stall_i & ~rst_i; combinational; one request at most per cycle.
REQ-017 Master side: address, we, be and wdata held stable until gnt; the block samples them only in the grant cycle.
REQ-018 Word index: address_i[2 +: log2(DEPTH)]; address_i[1:0] ignored.
REQ-019 In range: address_i[ADDRESS_SIZE-1:2] < DEPTH; otherwise out of range.
REQ-020 Granted in-range write: memory updated at the grant clock edge; only bytes with be[i]=1 written (byte i = wdata[8i+7:8i]).
REQ-021 Granted read: data captured at the grant clock edge; a later write to the same word does not alter the in-flight response.
REQ-022 Read following a write to the same word, granted the next cycle or later: returns the written data.
REQ-023 Every granted request (read or write) produces exactly one data_rvalid_o pulse, exactly LATENCY cycles after the grant cycle.
REQ-024 Responses are returned in grant order; back-to-back grants give back-to-back rvalid pulses, with no bubbles and no backpressure.
REQ-025 Response pipeline: a shift chain of LATENCY stages, each holding {valid, rdata, err}.
REQ-026 Write response: data_rdata_o = 0, err_o = 0.
REQ-027 Out-of-range read: data_rdata_o = 32'hDEADBEEF, err_o = 1.
REQ-028 Out-of-range write: memory unchanged, err_o = 1, data_rdata_o = 0.
REQ-029 When data_rvalid_o = 0: data_rdata_o = 0 and err_o = 0.
REQ-030 data_be_i = 0 on a write: no bytes change; a normal write response is still returned.
REQ-031 stall_i asserted while data_req_i is held: no grant; the request is accepted the first cycle stall_i is low.
REQ-032 Outputs data_rvalid_o, data_rdata_o and err_o are registered, driven from the final pipeline stage.

Reset
REQ-033 While rst_i = 1: all pipeline valid, rdata and err bits clear, and data_gnt_o = 0.
REQ-034 After reset: data_rvalid_o = 0, data_rdata_o = 0, err_o = 0.
REQ-035 Reset mid-operation: in-flight responses are discarded; no rvalid appears after deassertion for requests granted before reset.
REQ-036 Memory array contents are not reset; they persist across reset and are undefined at power-up.

Verification
REQ-037 LATENCY=1: write 0xA5A5_1234 to addr 0x10 with be=0xF, then read 0x10 -> each rvalid exactly 1 cycle after its gnt; read rdata = 0xA5A51234, err=0.
REQ-038 Partial write: be=0x2, wdata=0x0000_FF00 to addr 0x10, then read -> rdata = 0xA5A5FF34.
REQ-039 LATENCY=3: reads of 0x0, 0x4, 0x8 granted back-to-back -> three consecutive rvalid pulses, in order, starting 3 cycles after the first gnt.
REQ-040 DEPTH=1024: read of addr 0x1000 -> rvalid with rdata = 0xDEADBEEF, err=1; write of 0x1000 -> err=1 and word 0 unchanged.
REQ-041 stall_i high for 5 cycles with req held -> gnt=0 throughout; gnt in the 6th cycle; rvalid LATENCY cycles later.
REQ-042 LATENCY=2: grant a read, assert rst_i the next cycle for 1 cycle -> no rvalid ever observed for that read; outputs 0.
